// File: rtl/ex_mem_pkg.sv
// Shared pipeline definitions for the EX/MEM handshake controller:
// FSM encodings and performance-counter width.
package ex_mem_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } mem_state_e;

endpackage

// File: rtl/sat_cnt16.sv
// Saturating up-counter used for the memory performance counters.
module sat_cnt16
    import ex_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (inc && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/ex_mem_ctrl.sv
// EX->MEM stage register and data-memory handshake FSM: issues one-cycle
// Rd/Wr strobes, stalls the front end until Done, and counts accesses/hits.
module ex_mem_ctrl
    import ex_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_memRead,
    input  logic             ex_memWrite,
    input  logic             ex_createDump,
    input  logic [15:0]      ex_aluResult,
    input  logic [15:0]      ex_writeData,
    input  logic             flush,
    input  logic             mem_done,
    input  logic             mem_stall,
    input  logic             mem_hit,
    input  logic             mem_err,
    output logic [15:0]      aluResult,
    output logic [15:0]      writeData,
    output logic             memRead,
    output logic             memWrite,
    output logic             createDump,
    output logic             stall_up,
    output logic             mem_valid,
    output logic             err,
    output logic [CNT_W-1:0] cnt_access,
    output logic [CNT_W-1:0] cnt_hit
);

    mem_state_e  r_state;
    logic [15:0] r_alu;
    logic [15:0] r_wdata;
    logic        r_rd;
    logic        r_wr;
    logic        r_dump;
    logic        r_nm_valid;
    logic        r_err;

    logic w_busy;
    logic w_done;
    logic w_free;
    logic w_accept;
    logic w_is_mem;
    logic w_unused_stall;

    // Stall from the memory system is advisory; only Done retires an access.
    assign w_unused_stall = mem_stall;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_done   = w_busy & mem_done;
    assign w_free   = ~w_busy | mem_done;
    assign w_accept = w_free & ex_valid & ~flush;
    assign w_is_mem = ex_memRead | ex_memWrite;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_alu      <= '0;
            r_wdata    <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_dump     <= 1'b0;
            r_nm_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_busy && mem_err)
                r_err <= 1'b1;
            if (w_free) begin
                if (w_accept) begin
                    r_alu      <= ex_aluResult;
                    r_wdata    <= ex_writeData;
                    r_dump     <= ex_createDump;
                    // Conflicting Rd+Wr degrades to a read and flags an error.
                    r_rd       <= ex_memRead;
                    r_wr       <= ex_memWrite & ~ex_memRead;
                    r_nm_valid <= ~w_is_mem;
                    r_state    <= w_is_mem ? ST_REQ : ST_IDLE;
                    if (ex_memRead && ex_memWrite)
                        r_err <= 1'b1;
                end else begin
                    r_rd       <= 1'b0;
                    r_wr       <= 1'b0;
                    r_dump     <= 1'b0;
                    r_nm_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            end else begin
                r_rd       <= 1'b0;
                r_wr       <= 1'b0;
                r_nm_valid <= 1'b0;
                r_state    <= ST_WAIT;
            end
        end
    end

    assign aluResult  = r_alu;
    assign writeData  = r_wdata;
    assign memRead    = r_rd;
    assign memWrite   = r_wr;
    assign createDump = r_dump;
    assign err        = r_err;
    assign stall_up   = w_busy & ~mem_done;
    assign mem_valid  = r_nm_valid | w_done;

    sat_cnt16 u_cnt_access (
        .clk (clk),
        .rst (rst),
        .inc (w_done),
        .cnt (cnt_access)
    );

    sat_cnt16 u_cnt_hit (
        .clk (clk),
        .rst (rst),
        .inc (w_done & mem_hit),
        .cnt (cnt_hit)
    );

endmodule

// File: tb/tb_ex_mem_ctrl.sv
// Self-checking bench for ex_mem_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked each cycle against a model.
module tb_ex_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_memRead = 1'b0, ex_memWrite = 1'b0, ex_createDump = 1'b0;
    logic [15:0] ex_aluResult = '0, ex_writeData = '0;
    logic        flush = 1'b0;
    logic        mem_done = 1'b0, mem_stall = 1'b0, mem_hit = 1'b0, mem_err = 1'b0;
    logic [15:0] aluResult, writeData;
    logic        memRead, memWrite, createDump, stall_up, mem_valid, err;
    logic [15:0] cnt_access, cnt_hit;

    ex_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_createDump(ex_createDump), .ex_aluResult(ex_aluResult), .ex_writeData(ex_writeData),
        .flush(flush), .mem_done(mem_done), .mem_stall(mem_stall), .mem_hit(mem_hit),
        .mem_err(mem_err), .aluResult(aluResult), .writeData(writeData), .memRead(memRead),
        .memWrite(memWrite), .createDump(createDump), .stall_up(stall_up),
        .mem_valid(mem_valid), .err(err), .cnt_access(cnt_access), .cnt_hit(cnt_hit)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural model: an instruction is either "outstanding access" or a
    // non-memory op that retires one cycle after capture.
    bit          m_busy, m_first, m_pend, m_rd, m_wr, m_dump, m_err;
    logic [15:0] m_addr, m_data;
    int          m_cacc, m_chit;

    task automatic model_reset();
        m_busy = 0; m_first = 0; m_pend = 0; m_rd = 0; m_wr = 0; m_dump = 0; m_err = 0;
        m_addr = '0; m_data = '0; m_cacc = 0; m_chit = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) model_reset();
            chk16("cyc_aluResult", aluResult, m_addr);
            chk16("cyc_writeData", writeData, m_data);
            chk1("cyc_memRead", memRead, m_first && m_rd);
            chk1("cyc_memWrite", memWrite, m_first && m_wr);
            chk1("cyc_createDump", createDump, m_dump);
            chk1("cyc_stall_up", stall_up, m_busy && !mem_done);
            chk1("cyc_mem_valid", mem_valid, m_pend || (m_busy && mem_done));
            chk1("cyc_err", err, m_err);
            chk16("cyc_cnt_access", cnt_access, 16'(m_cacc));
            chk16("cyc_cnt_hit", cnt_hit, 16'(m_chit));
            if (rst) begin
                bit can;
                can = !m_busy || mem_done;
                if (m_busy && mem_done) begin
                    if (m_cacc < 65535) m_cacc++;
                    if (mem_hit && m_chit < 65535) m_chit++;
                end
                if (m_busy && mem_err) m_err = 1;
                if (can) begin
                    if (ex_valid && !flush) begin
                        m_addr  = ex_aluResult;
                        m_data  = ex_writeData;
                        m_dump  = ex_createDump;
                        m_rd    = ex_memRead;
                        m_wr    = ex_memWrite && !ex_memRead;
                        m_busy  = ex_memRead || ex_memWrite;
                        m_first = 1;
                        m_pend  = !m_busy;
                        if (ex_memRead && ex_memWrite) m_err = 1;
                    end else begin
                        m_busy = 0; m_pend = 0; m_dump = 0; m_first = 0;
                    end
                end else begin
                    m_first = 0; m_pend = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset low across a sampling edge, releases it just after a rising edge.
    task automatic release_reset();
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic clear_inputs();
        ex_valid = 0; ex_memRead = 0; ex_memWrite = 0; ex_createDump = 0;
        flush = 0; mem_done = 0; mem_stall = 0; mem_hit = 0; mem_err = 0;
    endtask

    initial begin
        int ns, nr;
        @(negedge clk);
        chk16("reset_cnt_access", cnt_access, 16'h0000);
        chk1("reset_mem_valid", mem_valid, 1'b0);
        chk1("reset_stall_up", stall_up, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Non-memory op
        ex_valid = 1; ex_aluResult = 16'h1234; ex_writeData = 16'hBEEF;
        @(negedge clk);
        chk1("nm_stall_cap", stall_up, 1'b0);
        tick(); ex_valid = 0;
        @(negedge clk);
        chk1("nm_valid", mem_valid, 1'b1);
        chk16("nm_addr", aluResult, 16'h1234);
        chk1("nm_stall", stall_up, 1'b0);
        chk16("nm_cnt", cnt_access, 16'h0000);
        tick();
        @(negedge clk);
        chk1("nm_valid_pulse", mem_valid, 1'b0);
        tick();

        // Load, Done on the fourth memory-stage cycle, miss
        ex_valid = 1; ex_memRead = 1; ex_aluResult = 16'h0040;
        tick(); ex_valid = 0; ex_memRead = 0; ex_aluResult = 16'h7777;
        ns = 0; nr = 0;
        for (int k = 0; k < 6; k++) begin
            mem_done = (k == 3);
            @(negedge clk);
            if (stall_up) ns++;
            if (memRead) nr++;
            if (k == 3) chk1("ld_valid", mem_valid, 1'b1);
            chk16("ld_addr_held", aluResult, 16'h0040);
            tick();
        end
        mem_done = 0;
        @(negedge clk);
        chk16("ld_stall_cycles", 16'(ns), 16'd3);
        chk16("ld_rd_cycles", 16'(nr), 16'd1);
        chk16("ld_cnt_access", cnt_access, 16'h0001);
        chk16("ld_cnt_hit", cnt_hit, 16'h0000);
        tick();

        // Store completing in the request cycle, hit
        ex_valid = 1; ex_memWrite = 1; ex_aluResult = 16'h0080; ex_writeData = 16'h5A5A;
        tick(); ex_valid = 0; ex_memWrite = 0; mem_done = 1; mem_hit = 1;
        @(negedge clk);
        chk1("st_stall", stall_up, 1'b0);
        chk1("st_valid", mem_valid, 1'b1);
        chk1("st_wr", memWrite, 1'b1);
        chk16("st_data", writeData, 16'h5A5A);
        tick(); mem_done = 0; mem_hit = 0;
        @(negedge clk);
        chk16("st_cnt_hit", cnt_hit, 16'h0001);
        chk16("st_cnt_access", cnt_access, 16'h0002);
        chk1("st_valid_end", mem_valid, 1'b0);
        tick();

        // Flush in IDLE drops the store; flush during WAIT is ignored
        ex_valid = 1; ex_memWrite = 1; flush = 1; ex_aluResult = 16'h00C0;
        tick(); ex_valid = 0; ex_memWrite = 0; flush = 0;
        @(negedge clk);
        chk1("fl_wr", memWrite, 1'b0);
        chk1("fl_valid", mem_valid, 1'b0);
        chk16("fl_addr_hold", aluResult, 16'h0080);
        tick();
        ex_valid = 1; ex_memRead = 1; ex_aluResult = 16'h0100;
        tick(); ex_valid = 0; ex_memRead = 0;
        tick(); flush = 1; ex_valid = 1; ex_memWrite = 1; ex_aluResult = 16'h0999;
        @(negedge clk);
        chk1("fl_wait_stall", stall_up, 1'b1);
        tick(); flush = 0; ex_valid = 0; ex_memWrite = 0; mem_done = 1;
        @(negedge clk);
        chk1("fl_wait_done", mem_valid, 1'b1);
        tick(); mem_done = 0;
        @(negedge clk);
        chk16("fl_cnt_access", cnt_access, 16'h0003);
        chk16("fl_addr2", aluResult, 16'h0100);
        tick();

        // Sticky error, cleared asynchronously by reset
        ex_valid = 1; ex_memRead = 1; ex_aluResult = 16'h0200;
        tick(); ex_valid = 0; ex_memRead = 0;
        tick(); mem_err = 1;
        tick(); mem_err = 0; mem_done = 1;
        @(negedge clk);
        chk1("er_set", err, 1'b1);
        tick(); mem_done = 0;
        repeat (3) tick();
        @(negedge clk);
        chk1("er_hold", err, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk1("er_clr_async", err, 1'b0);
        chk16("er_rst_cnt", cnt_access, 16'h0000);
        release_reset();

        // Read+write together: treated as a read, error flagged
        ex_valid = 1; ex_memRead = 1; ex_memWrite = 1; ex_aluResult = 16'h0300;
        tick(); ex_valid = 0; ex_memRead = 0; ex_memWrite = 0; mem_done = 1;
        @(negedge clk);
        chk1("bo_rd", memRead, 1'b1);
        chk1("bo_wr", memWrite, 1'b0);
        chk1("bo_err", err, 1'b1);
        tick(); mem_done = 0;
        tick();

        // Reset in the middle of WAIT
        ex_valid = 1; ex_memRead = 1; ex_aluResult = 16'h0400;
        tick(); ex_valid = 0; ex_memRead = 0;
        tick();
        @(negedge clk);
        chk1("rw_stall", stall_up, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk16("rw_addr", aluResult, 16'h0000);
        chk1("rw_rd", memRead, 1'b0);
        chk1("rw_stall_clr", stall_up, 1'b0);
        chk1("rw_valid", mem_valid, 1'b0);
        chk1("rw_err", err, 1'b0);
        release_reset();

        // Randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 2000; i++) begin
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_memRead    = $urandom_range(0, 1) == 1;
            ex_memWrite   = $urandom_range(0, 1) == 1;
            ex_createDump = ($urandom_range(0, 3) == 0);
            ex_aluResult  = 16'($urandom);
            ex_writeData  = 16'($urandom);
            flush         = ($urandom_range(0, 7) == 0);
            mem_done      = ($urandom_range(0, 2) == 0);
            mem_stall     = $urandom_range(0, 1) == 1;
            mem_hit       = $urandom_range(0, 1) == 1;
            mem_err       = ($urandom_range(0, 39) == 0);
            tick();
        end
        clear_inputs();
        rst = 1'b0;
        release_reset();

        // Counter saturation with back-to-back stores completing every cycle
        ex_valid = 1; ex_memWrite = 1; mem_done = 1; mem_hit = 1;
        repeat (65535) tick();
        @(negedge clk);
        chk16("sat_fffe", cnt_access, 16'hFFFE);
        repeat (3) tick();
        @(negedge clk);
        chk16("sat_ffff", cnt_access, 16'hFFFF);
        chk16("sat_hit_ffff", cnt_hit, 16'hFFFF);
        repeat (2) tick();
        @(negedge clk);
        chk16("sat_hold", cnt_access, 16'hFFFF);
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
